// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings,
// plus the shift-amount width helper.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_PASS = 4'h0,
    OP_NOT  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_NEG  = 4'h6,
    OP_SHR1 = 4'h7,
    OP_XOR  = 4'h8,
    OP_SHL1 = 4'h9,
    OP_SRA1 = 4'hA,
    OP_MUL  = 4'hB,
    OP_SHRV = 4'hC,
    OP_SHLV = 4'hD,
    OP_ADC  = 4'hE,
    OP_SBC  = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of b bits that form a variable shift amount.
  function automatic int shamt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Combinational datapath for every single-cycle opcode. The iterative
// opcodes (multiply, variable shifts) are handled in the top level and
// produce an all-zero result here.
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic             ovf
);

  logic signed [WIDTH-1:0] a_s;
  logic        [WIDTH:0]   sum;
  logic        [WIDTH:0]   dif;
  logic                    ci;

  // Two operands with the same sign producing a result of the other sign.
  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] z,
                                   input logic signed [WIDTH-1:0] r);
    return (x[WIDTH-1] == z[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Operands of differing sign where the result's sign differs from a.
  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] z,
                                   input logic signed [WIDTH-1:0] r);
    return (x[WIDTH-1] != z[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Result and flag selection for the single-cycle opcodes.
  always_comb begin
    a_s   = a;
    ci    = ((op == OP_ADC) || (op == OP_SBC)) ? cin : 1'b0;
    sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    dif   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, ci};
    y     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op_e'(op))
      OP_PASS: y = a;
      OP_NOT:  y = ~a;
      OP_ADD, OP_ADC: begin
        y     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = add_ovf(a, b, sum[WIDTH-1:0]);
      end
      OP_SUB, OP_SBC: begin
        y     = dif[WIDTH-1:0];
        carry = dif[WIDTH];
        ovf   = sub_ovf(a, b, dif[WIDTH-1:0]);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NEG: begin
        y     = -a;
        carry = |a;
        ovf   = (a == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_SHR1: begin
        y     = a >> 1;
        carry = a[0];
      end
      OP_SHL1: begin
        y     = a << 1;
        carry = a[WIDTH-1];
      end
      OP_SRA1: begin
        y     = a_s >>> 1;
        carry = a[0];
      end
      default: y = '0;
    endcase
    zero = (y == '0);
    neg  = y[WIDTH-1];
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes on both sides. Single-cycle
// opcodes complete on the acceptance edge; multiply and variable shifts
// iterate one bit per clock, the first iteration happening on acceptance.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int S = shamt_w(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic [S-1:0]       cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  logic [WIDTH-1:0]   c_y;
  logic               c_zero, c_carry, c_neg, c_ovf;

  logic               accept;
  logic [S-1:0]       shamt;
  logic [WIDTH:0]     step;
  logic [WIDTH:0]     first;
  logic [2*WIDTH-1:0] prod;
  logic               wr;
  logic [WIDTH-1:0]   wr_y;
  logic               wr_z, wr_c, wr_n, wr_v;

  // One bit-position shift; the bit shifted out is returned in the MSB.
  function automatic logic [WIDTH:0] shift_one(input logic [WIDTH-1:0] v,
                                               input logic             left);
    if (left) return {v, 1'b0};
    return {v[0], 1'b0, v[WIDTH-1:1]};
  endfunction

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .a     (a),
    .b     (b),
    .op    (op),
    .cin   (carry_q),
    .y     (c_y),
    .zero  (c_zero),
    .carry (c_carry),
    .neg   (c_neg),
    .ovf   (c_ovf)
  );

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign y         = y_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

  // Next-state, iteration and result-write logic.
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    wr       = 1'b0;
    wr_y     = '0;
    wr_z     = 1'b0;
    wr_c     = 1'b0;
    wr_n     = 1'b0;
    wr_v     = 1'b0;
    shamt    = b[S-1:0];
    step     = shift_one(acc_q[WIDTH-1:0], op_q == OP_SHLV);
    first    = shift_one(a, op == OP_SHLV);
    prod     = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q == OP_MUL) begin
          acc_d    = prod;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == S'(1)) begin
            wr      = 1'b1;
            wr_y    = prod[WIDTH-1:0];
            wr_c    = |prod[2*WIDTH-1:WIDTH];
            state_d = DONE;
          end
        end else begin
          acc_d = {{WIDTH{1'b0}}, step[WIDTH-1:0]};
          if (cnt_q == S'(1)) begin
            wr      = 1'b1;
            wr_y    = step[WIDTH-1:0];
            wr_c    = step[WIDTH];
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      op_d = op;
      case (op_e'(op))
        OP_MUL: begin
          acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
          mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
          mplier_d = b >> 1;
          cnt_d    = S'(WIDTH-1);
          state_d  = BUSY;
        end
        OP_SHRV, OP_SHLV: begin
          if (shamt == '0) begin
            wr      = 1'b1;
            wr_y    = a;
            state_d = DONE;
          end else if (shamt == S'(1)) begin
            wr      = 1'b1;
            wr_y    = first[WIDTH-1:0];
            wr_c    = first[WIDTH];
            state_d = DONE;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, first[WIDTH-1:0]};
            cnt_d   = shamt - 1'b1;
            state_d = BUSY;
          end
        end
        default: begin
          wr      = 1'b1;
          wr_y    = c_y;
          wr_c    = c_carry;
          wr_v    = c_ovf;
          state_d = DONE;
        end
      endcase
      if (op_e'(op) == OP_MUL || op_e'(op) == OP_SHRV || op_e'(op) == OP_SHLV) begin
        wr_z = (wr_y == '0);
        wr_n = wr_y[WIDTH-1];
      end else begin
        wr_z = c_zero;
        wr_n = c_neg;
      end
    end else begin
      wr_z = (wr_y == '0);
      wr_n = wr_y[WIDTH-1];
    end

    if (wr) begin
      y_d     = wr_y;
      zero_d  = wr_z;
      carry_d = wr_c;
      neg_d   = wr_n;
      ovf_d   = wr_v;
    end
  end

  // FSM, iteration counter and the visible result/flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand and accumulator registers; only meaningful while BUSY.
  always_ff @(posedge clk) begin
    op_q     <= op_d;
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: directed vectors plus a transaction-level
// scoreboard that predicts every result and its timing.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic [3:0] op = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] y;
  logic       zero, carry, neg, ovf;
  logic       out_valid;
  logic       out_ready = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .zero      (zero),
    .carry     (carry),
    .neg       (neg),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] y;
    logic       c;
    logic       v;
  } res_t;

  typedef struct {
    res_t r;
    int   due;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of each opcode, in plain integer arithmetic.
  function automatic res_t model_op(input logic [3:0] o, input logic [7:0] xa,
                                    input logic [7:0] xb, input logic ci);
    res_t r;
    int ua, ub, sa, sb, k, full, sfull, n;
    ua = xa; ub = xb; sa = $signed(xa); sb = $signed(xb);
    k = ((o == 4'hE) || (o == 4'hF)) ? int'(ci) : 0;
    r.c = 1'b0; r.v = 1'b0; full = 0; sfull = 0; n = ub % 8;
    case (o)
      4'h0: full = ua;
      4'h1: full = 255 - ua;
      4'h2, 4'hE: begin
        full = ua + ub + k; sfull = sa + sb + k;
        r.c = (full > 255); r.v = (sfull > 127) || (sfull < -128);
      end
      4'h3, 4'hF: begin
        full = ua - ub - k; sfull = sa - sb - k;
        r.c = (full < 0); r.v = (sfull > 127) || (sfull < -128);
      end
      4'h4: full = ua & ub;
      4'h5: full = ua | ub;
      4'h8: full = ua ^ ub;
      4'h6: begin full = -ua; r.c = (ua != 0); r.v = (ua == 128); end
      4'h7: begin full = ua / 2; r.c = (ua % 2 == 1); end
      4'h9: begin full = ua * 2; r.c = (ua >= 128); end
      4'hA: begin full = sa >>> 1; r.c = (ua % 2 == 1); end
      4'hB: begin full = ua * ub; r.c = (full > 255); end
      4'hC: begin full = ua >> n; r.c = (n > 0) && (((ua >> (n - 1)) % 2) == 1); end
      default: begin full = ua << n; r.c = (n > 0) && (((full >> 8) % 2) == 1); end
    endcase
    r.y = full[7:0];
    return r;
  endfunction

  function automatic int lat_of(input logic [3:0] o, input logic [7:0] xb);
    int n;
    n = xb % 8;
    if (o == 4'hB) return 8;
    if ((o == 4'hC) || (o == 4'hD)) return (n == 0) ? 1 : n;
    return 1;
  endfunction

  // Scoreboard: one outstanding operation at most; predicts out_valid,
  // in_ready, y and the flags every cycle.
  exp_t q[$];
  logic mcarry = 1'b0;
  logic exp_ov, exp_ir;
  res_t mres;
  exp_t ent;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_y", y, 0);
      chk("rst_flags", {zero, carry, neg, ovf}, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      q.delete();
      mcarry = 1'b0;
    end else begin
      exp_ov = (q.size() != 0) && (cyc >= q[0].due);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov && out_valid) begin
        chk("y", y, q[0].r.y);
        chk("carry", carry, q[0].r.c);
        chk("ovf", ovf, q[0].r.v);
        chk("zero", zero, q[0].r.y == 8'h00);
        chk("neg", neg, q[0].r.y[7]);
      end
      exp_ir = (q.size() == 0) || (exp_ov && out_ready);
      chk("in_ready", in_ready, exp_ir);
      if (exp_ov && out_ready) void'(q.pop_front());
      if (in_valid && exp_ir) begin
        mres    = model_op(op, a, b, mcarry);
        mcarry  = mres.c;
        ent.r   = mres;
        ent.due = cyc + lat_of(op, b);
        q.push_back(ent);
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Present an operation and return one step after the edge that takes it.
  task automatic issue(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb);
    int t;
    t = 0;
    op = o; a = xa; b = xb; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 100);
    if (!out_valid) chk("result_timeout", out_valid, 1);
  endtask

  logic [3:0] t_op [17] = '{4'h1, 4'h4, 4'h5, 4'h6, 4'h6, 4'h7, 4'h9, 4'hA, 4'h8,
                            4'h2, 4'hE, 4'hF, 4'h3, 4'h0, 4'hD, 4'hC, 4'hB};
  logic [7:0] t_a  [17] = '{8'h5A, 8'hF0, 8'hF0, 8'h80, 8'h00, 8'h81, 8'h81, 8'h81, 8'hAA,
                            8'hFF, 8'h01, 8'h00, 8'h80, 8'h00, 8'h81, 8'hF1, 8'hFF};
  logic [7:0] t_b  [17] = '{8'h00, 8'h3C, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55,
                            8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h07, 8'h05, 8'hFF};

  res_t pin;
  int   lat;

  initial begin
    // model pins
    pin = model_op(4'h2, 8'h7F, 8'h01, 1'b0);
    chk("pin_add", {pin.y, pin.c, pin.v}, {8'h80, 1'b0, 1'b1});
    pin = model_op(4'hF, 8'h10, 8'h01, 1'b1);
    chk("pin_sbc", {pin.y, pin.c}, {8'h0E, 1'b0});
    pin = model_op(4'hB, 8'h12, 8'h10, 1'b0);
    chk("pin_mul", {pin.y, pin.c}, {8'h20, 1'b1});
    pin = model_op(4'hD, 8'h81, 8'h01, 1'b0);
    chk("pin_shlv", {pin.y, pin.c}, {8'h02, 1'b1});
    chk("pin_lat_shrv", lat_of(4'hC, 8'h03), 3);

    #1 reset_n = 1'b0;
    #1;
    chk("reset_y", y, 0);
    chk("reset_flags", {zero, carry, neg, ovf}, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    sync();
    issue(4'h2, 8'h7F, 8'h01);
    wait_result(lat);
    chk("add_lat", lat, 1);
    chk("add_y", y, 8'h80);
    chk("add_flags", {zero, carry, neg, ovf}, 4'b0011);

    sync();
    issue(4'h3, 8'h05, 8'h07);
    wait_result(lat);
    chk("sub_y", y, 8'hFE);
    chk("sub_carry", carry, 1);
    sync();
    issue(4'hF, 8'h10, 8'h01);
    wait_result(lat);
    chk("sbc_y", y, 8'h0E);
    chk("sbc_carry", carry, 0);

    sync();
    issue(4'hB, 8'h12, 8'h10);
    chk("mul_busy_in_ready", in_ready, 0);
    wait_result(lat);
    chk("mul_lat", lat, 8);
    chk("mul_y", y, 8'h20);
    chk("mul_carry", carry, 1);

    sync();
    issue(4'hC, 8'h80, 8'h03);
    wait_result(lat);
    chk("shrv3_lat", lat, 3);
    chk("shrv3_y", y, 8'h10);
    sync();
    issue(4'hC, 8'h80, 8'h00);
    wait_result(lat);
    chk("shrv0_lat", lat, 1);
    chk("shrv0_y", y, 8'h80);
    chk("shrv0_carry", carry, 0);
    sync();
    issue(4'hD, 8'h81, 8'h01);
    wait_result(lat);
    chk("shlv1_y", y, 8'h02);
    chk("shlv1_carry", carry, 1);

    // backpressure, then back-to-back acceptance on the release edge
    sync();
    out_ready = 1'b0;
    issue(4'h2, 8'h03, 8'h04);
    wait_result(lat);
    chk("bp_first_y", y, 8'h07);
    #2;
    op = 4'h8; a = 8'hF0; b = 8'h0F; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_y_stable", y, 8'h07);
      chk("bp_flags_stable", {zero, carry, neg, ovf}, 4'b0000);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_out_valid", out_valid, 1);
    chk("b2b_y", y, 8'hFF);

    // reset in the middle of a multiply
    sync();
    issue(4'hB, 8'h0F, 8'h0F);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_y", y, 0);
    chk("midrst_flags", {zero, carry, neg, ovf}, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    issue(4'hB, 8'h03, 8'h05);
    wait_result(lat);
    chk("postrst_mul_lat", lat, 8);
    chk("postrst_mul_y", y, 8'h0F);

    // back-to-back sweep over every opcode, checked by the scoreboard
    sync();
    for (int i = 0; i < 17; i++) issue(t_op[i], t_a[i], t_b[i]);
    repeat (20) @(negedge clk);
    chk("drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
